// File: rtl/accum_averager_pkg.sv
// Shared widths, FSM state type and saturation limits for the accumulator/averager pair.
package accum_pkg;

    localparam int DEF_SUM_W = 48;
    localparam int DEF_LEN_W = 18;
    localparam int DEF_OUT_W = 31;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIN
    } state_t;

    localparam logic signed [DEF_OUT_W-1:0] SAT_MAX = {1'b0, {(DEF_OUT_W-1){1'b1}}};
    localparam logic signed [DEF_OUT_W-1:0] SAT_MIN = {1'b1, {(DEF_OUT_W-1){1'b0}}};

endpackage

// File: rtl/accum_averager_if.sv
// Sum/length input stream and mean/status output bundle of the averager.
interface accum_averager_if
    import accum_pkg::*;
#(
    parameter int SUM_W = DEF_SUM_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int OUT_W = DEF_OUT_W
);
    logic                    valid_in;
    logic [LEN_W-1:0]        length;
    logic signed [SUM_W-1:0] sum_in;
    logic                    valid_out;
    logic signed [OUT_W-1:0] mean_out;
    logic                    div_err;
    logic                    overflow;

    modport master (
        output valid_in, length, sum_in,
        input  valid_out, mean_out, div_err, overflow
    );

    modport slave (
        input  valid_in, length, sum_in,
        output valid_out, mean_out, div_err, overflow
    );
endinterface

// File: rtl/accum_averager_serial_divider.sv
// Unsigned restoring divider, one quotient bit per clock, DVD_W steps after start.
module serial_divider #(
    parameter int DVD_W = 48,
    parameter int DVS_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);
    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [CNT_W-1:0] cnt;
    logic [DVD_W-1:0] dvd_p0;
    logic [DVS_W-1:0] dvs_p0;
    logic [DVS_W-1:0] rem_p0;
    logic [DVS_W:0]   rem_shift;
    logic [DVS_W-1:0] rem_sub;
    logic             ge;

    // rem < divisor after every step, so the difference always fits in DVS_W bits
    always_comb begin
        rem_shift = {rem_p0, dvd_p0[DVD_W-1]};
        ge        = (rem_shift >= {1'b0, dvs_p0});
        rem_sub   = rem_shift[DVS_W-1:0] - dvs_p0;
    end

    assign done = (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CNT_W'(DVD_W);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            dvd_p0   <= dividend;
            dvs_p0   <= divisor;
            rem_p0   <= '0;
            quotient <= '0;
        end else if (cnt != '0) begin
            dvd_p0   <= {dvd_p0[DVD_W-2:0], 1'b0};
            rem_p0   <= ge ? rem_sub : rem_shift[DVS_W-1:0];
            quotient <= {quotient[DVD_W-2:0], ge};
        end
    end
endmodule

// File: rtl/accum_averager.sv
// Divides each accumulated sum by its length into a saturated sample-domain mean.
// Optional ACCUM_AVG_ROUND_EN: round half away from zero instead of truncating.
module accum_averager
    import accum_pkg::*;
#(
    parameter int SUM_W = DEF_SUM_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    accum_averager_if.slave  bus
);
`ifdef ACCUM_AVG_ROUND_EN
    localparam int DVD_W = SUM_W + 1;
`else
    localparam int DVD_W = SUM_W;
`endif

    localparam logic signed [OUT_W-1:0] MEAN_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MEAN_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [DVD_W-1:0] POS_LIM = {{(DVD_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [DVD_W-1:0] NEG_LIM = POS_LIM + 1'b1;

    state_t                  state;
    logic                    pend_full;
    logic signed [SUM_W-1:0] pend_sum;
    logic [LEN_W-1:0]        pend_len;
    logic                    load;
    logic                    pend_wr;
    logic                    pend_drop;
    logic signed [SUM_W-1:0] ld_sum;
    logic [LEN_W-1:0]        ld_len;
    logic [SUM_W-1:0]        ld_abs;
    logic [DVD_W-1:0]        ld_mag;
    logic                    neg_p0;
    logic                    zero_p0;
    logic                    div_done;
    logic [DVD_W-1:0]        quot;
    logic signed [OUT_W-1:0] res_p1;
    logic                    vld_p1;
    logic                    err_p1;

    function automatic logic signed [OUT_W-1:0] sat_mean(input logic [DVD_W-1:0] q,
                                                         input logic neg);
        if (!neg) begin
            return (q > POS_LIM) ? MEAN_MAX : $signed(q[OUT_W-1:0]);
        end
        return (q > NEG_LIM) ? MEAN_MIN : -$signed(q[OUT_W-1:0]);
    endfunction

    // Pending slot wins over a simultaneous new input; the new input then takes its place
    always_comb begin
        load      = ((state == IDLE) || (state == FIN)) && (pend_full || bus.valid_in);
        ld_sum    = pend_full ? pend_sum : bus.sum_in;
        ld_len    = pend_full ? pend_len : bus.length;
        pend_wr   = bus.valid_in && ((load && pend_full) || (!load && !pend_full));
        pend_drop = bus.valid_in && !load && pend_full;
        ld_abs    = ld_sum[SUM_W-1] ? (~ld_sum + 1'b1) : ld_sum;
`ifdef ACCUM_AVG_ROUND_EN
        ld_mag    = {1'b0, ld_abs} + DVD_W'(ld_len >> 1);
`else
        ld_mag    = ld_abs;
`endif
    end

    serial_divider #(
        .DVD_W (DVD_W),
        .DVS_W (LEN_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (load),
        .dividend (ld_mag),
        .divisor  (ld_len),
        .done     (div_done),
        .quotient (quot)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            pend_full     <= 1'b0;
            vld_p1        <= 1'b0;
            err_p1        <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.valid_out <= 1'b0;
            bus.div_err   <= 1'b0;
            bus.mean_out  <= '0;
        end else begin
            case (state)
                IDLE:    if (load) state <= DIV;
                DIV:     if (div_done) state <= FIN;
                FIN:     state <= load ? DIV : IDLE;
                default: state <= IDLE;
            endcase

            if (pend_wr) begin
                pend_full <= 1'b1;
            end else if (load && pend_full) begin
                pend_full <= 1'b0;
            end
            if (pend_drop) begin
                bus.overflow <= 1'b1;
            end

            // p1 -> output register
            vld_p1        <= (state == FIN);
            err_p1        <= (state == FIN) && zero_p0;
            bus.valid_out <= vld_p1;
            bus.div_err   <= err_p1;
            if (vld_p1) begin
                bus.mean_out <= res_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pend_wr) begin
            pend_sum <= bus.sum_in;
            pend_len <= bus.length;
        end
        // load -> p0 work registers
        if (load) begin
            neg_p0  <= ld_sum[SUM_W-1];
            zero_p0 <= (ld_len == '0);
        end
        // FIN -> p1 signed, saturated result
        if (state == FIN) begin
            res_p1 <= zero_p0 ? '0 : sat_mean(quot, neg_p0);
        end
    end
endmodule
